// File: rtl/issue_select.sv
// Oldest-first select stage: age-matrix pick, registered issue port with valid/ready, free pulses.
// Optional ISSUE_SELECT_PERF_EN adds saturating stall and handshake counters.
module issue_select #(
    parameter int unsigned NUM_ROWS = 8,
    localparam int unsigned ROW_W = $clog2(NUM_ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] request_vector_i,
    input  logic                alloc_en_i,
    input  logic [ROW_W-1:0]    alloc_row_i,
    input  logic                flush_i,
    output logic                issue_valid_o,
    output logic [ROW_W-1:0]    issue_row_o,
    input  logic                issue_ready_i,
    output logic                free_en_o,
    output logic [ROW_W-1:0]    free_row_index_o
`ifdef ISSUE_SELECT_PERF_EN
    ,
    output logic [31:0]         stall_cycles_o,
    output logic [31:0]         issued_count_o
`endif
);

    logic [NUM_ROWS-1:0] valid_q, valid_d;
    logic [NUM_ROWS-1:0] age_q [NUM_ROWS];
    logic [NUM_ROWS-1:0] age_d [NUM_ROWS];
    logic                issue_valid_q, issue_valid_d;
    logic [ROW_W-1:0]    issue_row_q, issue_row_d;
    logic                free_en_q, free_en_d;
    logic [ROW_W-1:0]    free_row_q, free_row_d;

    logic [NUM_ROWS-1:0] hold_mask;
    logic [NUM_ROWS-1:0] elig;
    logic [NUM_ROWS-1:0] has_older;
    logic                pick_found;
    logic [ROW_W-1:0]    pick_row;
    logic                load_en;
    logic                handshake;

    assign load_en   = !issue_valid_q || issue_ready_i;
    assign handshake = issue_valid_q && issue_ready_i;

    always_comb begin
        hold_mask = '0;
        if (issue_valid_q) begin
            hold_mask[issue_row_q] = 1'b1;
        end
        elig = request_vector_i & valid_q & ~hold_mask;
    end

    always_comb begin
        has_older = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            for (int j = 0; j < NUM_ROWS; j++) begin
                if (elig[j] && age_q[j][i]) begin
                    has_older[i] = 1'b1;
                end
            end
        end
    end

    // Lowest index wins among rows with no older eligible row; inconsistent age falls back to
    // the lowest eligible index so a pick is always made when elig is non-zero.
    always_comb begin
        pick_found = 1'b0;
        pick_row   = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!pick_found && elig[i] && !has_older[i]) begin
                pick_found = 1'b1;
                pick_row   = ROW_W'(i);
            end
        end
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!pick_found && elig[i]) begin
                pick_found = 1'b1;
                pick_row   = ROW_W'(i);
            end
        end
    end

    always_comb begin
        valid_d       = valid_q;
        age_d         = age_q;
        issue_valid_d = issue_valid_q;
        issue_row_d   = issue_row_q;
        free_en_d     = 1'b0;
        free_row_d    = free_row_q;

        if (handshake) begin
            valid_d[issue_row_q] = 1'b0;
            free_en_d            = 1'b1;
            free_row_d           = issue_row_q;
        end

        if (load_en) begin
            issue_valid_d = |elig;
            if (|elig) begin
                issue_row_d = pick_row;
            end
        end

        // Applied after the handshake clear so a same-cycle re-allocation keeps the row valid.
        if (alloc_en_i) begin
            valid_d[alloc_row_i] = 1'b1;
            for (int j = 0; j < NUM_ROWS; j++) begin
                age_d[alloc_row_i][j] = 1'b0;
            end
            for (int j = 0; j < NUM_ROWS; j++) begin
                if (ROW_W'(j) != alloc_row_i) begin
                    age_d[j][alloc_row_i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_row_q   <= '0;
            free_en_q     <= 1'b0;
            free_row_q    <= '0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            issue_valid_q <= issue_valid_d;
            issue_row_q   <= issue_row_d;
            free_en_q     <= free_en_d;
            free_row_q    <= free_row_d;
            for (int i = 0; i < NUM_ROWS; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign issue_valid_o    = issue_valid_q;
    assign issue_row_o      = issue_row_q;
    assign free_en_o        = free_en_q;
    assign free_row_index_o = free_row_q;

`ifdef ISSUE_SELECT_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] issued_count_q;

    // Counters survive flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            issued_count_q <= '0;
        end else begin
            if (issue_valid_q && !issue_ready_i && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (handshake && (issued_count_q != '1)) begin
                issued_count_q <= issued_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign issued_count_o = issued_count_q;
`else
    // Performance counters not built.
`endif

    alloc_row_free_a: assert property (@(posedge clk) disable iff (rst || flush_i)
        alloc_en_i |-> (!valid_q[alloc_row_i] || (handshake && (issue_row_q == alloc_row_i))));

endmodule
